// File: rtl/player_pkg.sv
// Shared types and default physics constants for the per-player motion engine,
// also used by the renderer and the collision block.
package player_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } mstate_t;

  localparam int DEF_STEP     = 1;
  localparam int DEF_GRAVITY  = 1;
  localparam int DEF_JUMP_V   = 12;
  localparam int DEF_JUMP_CUT = 4;
  localparam int DEF_MAX_FALL = 14;
  localparam int DEF_COYOTE   = 3;
  localparam int DEF_JBUF     = 3;
  localparam int DEF_X_MAX    = 639;
  localparam int DEF_Y_MAX    = 479;
  localparam int TICK_CNT_W   = 4;

  // Bits needed to hold a counter that starts at max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/player_motion_tick_counter.sv
// Small down-counter: clear beats load beats decrement; stops at zero.
module tick_counter
  import player_pkg::*;
#(
  parameter int W = TICK_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Counter register with clear/load/decrement priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    count <= '0;
    else if (clr)                  count <= '0;
    else if (load)                 count <= load_val;
    else if (dec && count != '0)   count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/player_motion.sv
// Per-player motion engine: walking, buffered/coyote jumps, variable jump
// height, gravity with terminal velocity, clamping and respawn.
module player_motion
  import player_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int V_W      = 6,
  parameter int STEP     = DEF_STEP,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int JUMP_V   = DEF_JUMP_V,
  parameter int JUMP_CUT = DEF_JUMP_CUT,
  parameter int MAX_FALL = DEF_MAX_FALL,
  parameter int COYOTE   = DEF_COYOTE,
  parameter int JBUF     = DEF_JBUF,
  parameter int X_MAX    = DEF_X_MAX,
  parameter int Y_MAX    = DEF_Y_MAX,
  parameter int INIT_X   = 16,
  parameter int INIT_Y   = 400
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  move_left,
  input  logic                  move_right,
  input  logic                  jump_btn,
  input  logic                  blk_up,
  input  logic                  blk_down,
  input  logic                  blk_left,
  input  logic                  blk_right,
  input  logic                  respawn,
  input  logic [X_W-1:0]        spawn_x,
  input  logic [Y_W-1:0]        spawn_y,
  output logic [X_W-1:0]        pos_x,
  output logic [Y_W-1:0]        pos_y,
  output logic signed [V_W-1:0] vel_y,
  output logic                  facing,
  output logic                  walking,
  output logic [1:0]            mstate
);

  localparam int JB_W = cnt_width(JBUF);
  localparam int CY_W = cnt_width(COYOTE);
  localparam int XW1  = X_W + 1;
  localparam int YW1  = Y_W + 1;

  localparam logic [X_W-1:0]        STEP_X  = X_W'(STEP);
  localparam logic [X_W:0]          XMAX_E  = XW1'(X_MAX);
  localparam logic [X_W-1:0]        XMAX_X  = X_W'(X_MAX);
  localparam logic [Y_W-1:0]        YMAX_Y  = Y_W'(Y_MAX);
  localparam logic signed [Y_W:0]   YMAX_S  = YW1'(Y_MAX);
  localparam logic signed [V_W-1:0] V_ZERO  = '0;
  localparam logic signed [V_W-1:0] V_GRAV  = V_W'(GRAVITY);
  localparam logic signed [V_W-1:0] V_JUMP  = V_W'(JUMP_V);
  localparam logic signed [V_W-1:0] V_CUT   = V_W'(JUMP_CUT);
  localparam logic signed [V_W-1:0] V_FLOOR = -V_W'(MAX_FALL);

  function automatic logic [X_W-1:0] step_left(input logic [X_W-1:0] x);
    return (x < STEP_X) ? '0 : x - STEP_X;
  endfunction

  function automatic logic [X_W-1:0] step_right(input logic [X_W-1:0] x);
    logic [X_W:0] s;
    s = {1'b0, x} + {1'b0, STEP_X};
    return (s >= XMAX_E) ? XMAX_X : s[X_W-1:0];
  endfunction

  // Gravity applied while falling, saturated at terminal velocity.
  function automatic logic signed [V_W-1:0] fall_vel(input logic signed [V_W-1:0] v);
    logic signed [V_W-1:0] d;
    d = v - V_GRAV;
    return (d < V_FLOOR) ? V_FLOOR : d;
  endfunction

  // y - v in one extra signed bit, clamped to the visible range.
  function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] y,
                                             input logic signed [V_W-1:0] v);
    logic signed [Y_W:0] t;
    t = $signed({1'b0, y}) - $signed({{(Y_W + 1 - V_W){v[V_W-1]}}, v});
    if (t[Y_W])       return '0;
    if (t >= YMAX_S)  return YMAX_Y;
    return t[Y_W-1:0];
  endfunction

  logic [X_W-1:0]        x_p1, x_nx;
  logic [Y_W-1:0]        y_p1, y_nx;
  logic signed [V_W-1:0] vel_p1, vel_nx;
  mstate_t               st_p1, st_nx;
  logic                  facing_p1, facing_nx;
  logic                  walking_p1, walking_nx;
  logic                  jump_p1;
  logic                  jump_edge, launch;
  logic                  jb_zero, cy_zero;
  logic                  cy_load, cy_dec;

  assign jump_edge = jump_btn & ~jump_p1;
  assign launch    = tick & (jump_edge | ~jb_zero) &
                     ((st_p1 == GROUND) | ~cy_zero) & ~blk_up;

  tick_counter #(.W(JB_W)) u_jbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (respawn | launch),
    .load     (jump_edge),
    .dec      (tick),
    .load_val (JB_W'(JBUF)),
    .zero     (jb_zero)
  );

  tick_counter #(.W(CY_W)) u_coyote (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (respawn | launch),
    .load     (cy_load),
    .dec      (cy_dec),
    .load_val (CY_W'(COYOTE)),
    .zero     (cy_zero)
  );

  // Next-state logic: horizontal datapath plus the vertical FSM, active on tick.
  always_comb begin
    x_nx       = x_p1;
    y_nx       = y_p1;
    vel_nx     = vel_p1;
    st_nx      = st_p1;
    facing_nx  = facing_p1;
    walking_nx = walking_p1;
    cy_load    = 1'b0;
    cy_dec     = 1'b0;
    if (tick) begin
      walking_nx = 1'b0;
      if (move_left && !move_right) begin
        facing_nx = 1'b1;
        if (!blk_left) begin
          walking_nx = 1'b1;
          x_nx       = step_left(x_p1);
        end
      end else if (move_right && !move_left) begin
        facing_nx = 1'b0;
        if (!blk_right) begin
          walking_nx = 1'b1;
          x_nx       = step_right(x_p1);
        end
      end

      if (launch) begin
        vel_nx = V_JUMP;
        st_nx  = RISE;
      end else begin
        case (st_p1)
          GROUND: begin
            vel_nx = V_ZERO;
            if (!blk_down) begin
              st_nx   = FALL;
              cy_load = 1'b1;
            end
          end
          RISE: begin
            if (blk_up) begin
              vel_nx = V_ZERO;
              st_nx  = FALL;
            end else begin
              vel_nx = vel_p1 - V_GRAV;
              if (!jump_btn && vel_nx > V_CUT) vel_nx = V_CUT;
              if (vel_nx <= V_ZERO) st_nx = FALL;
            end
          end
          FALL: begin
            if (blk_down) begin
              vel_nx = V_ZERO;
              st_nx  = GROUND;
            end else begin
              vel_nx = fall_vel(vel_p1);
              cy_dec = 1'b1;
            end
          end
          default: begin
            vel_nx = V_ZERO;
            st_nx  = FALL;
          end
        endcase
      end

      y_nx = clamp_y(y_p1, vel_nx);
      if (y_nx == YMAX_Y) begin
        vel_nx = V_ZERO;
        st_nx  = GROUND;
      end
    end
  end

  // Output stage: registered motion state; respawn overrides any tick update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_p1       <= X_W'(INIT_X);
      y_p1       <= Y_W'(INIT_Y);
      vel_p1     <= V_ZERO;
      st_p1      <= FALL;
      facing_p1  <= 1'b0;
      walking_p1 <= 1'b0;
      jump_p1    <= 1'b0;
    end else begin
      jump_p1 <= jump_btn;
      if (respawn) begin
        x_p1       <= spawn_x;
        y_p1       <= spawn_y;
        vel_p1     <= V_ZERO;
        st_p1      <= FALL;
        walking_p1 <= 1'b0;
      end else begin
        x_p1       <= x_nx;
        y_p1       <= y_nx;
        vel_p1     <= vel_nx;
        st_p1      <= st_nx;
        facing_p1  <= facing_nx;
        walking_p1 <= walking_nx;
      end
    end
  end

  assign pos_x   = x_p1;
  assign pos_y   = y_p1;
  assign vel_y   = vel_p1;
  assign facing  = facing_p1;
  assign walking = walking_p1;
  assign mstate  = st_p1;

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: constant vector table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_player_motion;

  localparam int JUMP_V   = 12;
  localparam int JUMP_CUT = 4;
  localparam int MAX_FALL = 14;
  localparam int COYOTE   = 3;
  localparam int JBUF     = 3;
  localparam int X_MAX    = 639;
  localparam int Y_MAX    = 479;
  localparam int INIT_X   = 16;
  localparam int INIT_Y   = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0, move_left = 1'b0, move_right = 1'b0, jump_btn = 1'b0;
  logic blk_up = 1'b0, blk_down = 1'b0, blk_left = 1'b0, blk_right = 1'b0;
  logic respawn = 1'b0;
  logic [9:0] spawn_x = '0;
  logic [8:0] spawn_y = '0;
  logic [9:0] pos_x;
  logic [8:0] pos_y;
  logic signed [5:0] vel_y;
  logic facing, walking;
  logic [1:0] mstate;

  int n_cmp = 0;
  int n_bad = 0;

  player_motion dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .move_left  (move_left),
    .move_right (move_right),
    .jump_btn   (jump_btn),
    .blk_up     (blk_up),
    .blk_down   (blk_down),
    .blk_left   (blk_left),
    .blk_right  (blk_right),
    .respawn    (respawn),
    .spawn_x    (spawn_x),
    .spawn_y    (spawn_y),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .vel_y      (vel_y),
    .facing     (facing),
    .walking    (walking),
    .mstate     (mstate)
  );

  always #5 clk = ~clk;

  // Behavioural model state (plain integers, rules applied directly).
  int m_x, m_y, m_v, m_s, m_jb, m_cy;
  bit m_f, m_w, m_jq;

  task automatic model_reset();
    m_x = INIT_X; m_y = INIT_Y; m_v = 0; m_s = 2;
    m_f = 1'b0; m_w = 1'b0; m_jb = 0; m_cy = 0; m_jq = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_clk();
    bit edge_now, go;
    int ny;
    edge_now = jump_btn && !m_jq;
    m_jq = jump_btn;
    if (respawn) begin
      m_x = int'(spawn_x); m_y = int'(spawn_y); m_v = 0; m_s = 2;
      m_w = 1'b0; m_jb = 0; m_cy = 0;
      return;
    end
    if (!tick) begin
      if (edge_now) m_jb = JBUF;
      return;
    end
    if (move_left && !move_right) begin
      m_f = 1'b1; m_w = !blk_left;
      if (!blk_left) m_x = (m_x - 1 < 0) ? 0 : m_x - 1;
    end else if (move_right && !move_left) begin
      m_f = 1'b0; m_w = !blk_right;
      if (!blk_right) m_x = (m_x + 1 > X_MAX) ? X_MAX : m_x + 1;
    end else begin
      m_w = 1'b0;
    end
    go = (edge_now || m_jb > 0) && (m_s == 0 || m_cy > 0) && !blk_up;
    if (go) begin
      m_v = JUMP_V; m_s = 1; m_jb = 0; m_cy = 0;
    end else begin
      if (edge_now) m_jb = JBUF;
      else if (m_jb > 0) m_jb = m_jb - 1;
      if (m_s == 0) begin
        m_v = 0;
        if (!blk_down) begin m_s = 2; m_cy = COYOTE; end
      end else if (m_s == 1) begin
        if (blk_up) begin m_v = 0; m_s = 2; end
        else begin
          m_v = m_v - 1;
          if (!jump_btn && m_v > JUMP_CUT) m_v = JUMP_CUT;
          if (m_v <= 0) m_s = 2;
        end
      end else begin
        if (blk_down) begin m_v = 0; m_s = 0; end
        else begin
          m_v = (m_v - 1 < -MAX_FALL) ? -MAX_FALL : m_v - 1;
          if (m_cy > 0) m_cy = m_cy - 1;
        end
      end
    end
    ny = m_y - m_v;
    if (ny < 0) ny = 0;
    if (ny >= Y_MAX) begin ny = Y_MAX; m_v = 0; m_s = 0; end
    m_y = ny;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "/x"},    int'(pos_x),   m_x);
    chk({tag, "/y"},    int'(pos_y),   m_y);
    chk({tag, "/vel"},  int'(vel_y),   m_v);
    chk({tag, "/st"},   int'(mstate),  m_s);
    chk({tag, "/face"}, int'(facing),  int'(m_f));
    chk({tag, "/walk"}, int'(walking), int'(m_w));
  endtask

  // One clock: model steps on the applied inputs, DUT sampled 1 ns after the edge.
  task automatic step(input bit t, input string tag);
    tick = t;
    model_clk();
    @(posedge clk);
    #1;
    cmp_model(tag);
    tick = 1'b0;
  endtask

  task automatic keys(input bit l, input bit r, input bit j);
    move_left = l; move_right = r; jump_btn = j;
  endtask

  task automatic blk(input bit u, input bit d);
    blk_up = u; blk_down = d;
  endtask

  task automatic do_respawn(input int x, input int y);
    spawn_x = 10'(x); spawn_y = 9'(y); respawn = 1'b1;
    step(1'b1, "respawn");
    respawn = 1'b0;
    chk("respawn_x", int'(pos_x), x);
    chk("respawn_y", int'(pos_y), y);
    chk("respawn_st", int'(mstate), 2);
  endtask

  typedef struct {
    int t, l, r, bl, bd;
    int ex, ey, ev, es, ef, ew;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // t  l  r bl bd   x    y   v st  f  w
    tbl[0] = '{1, 0, 1, 0, 1, 17, 400, 0, 0, 0, 1};
    tbl[1] = '{1, 0, 1, 0, 1, 18, 400, 0, 0, 0, 1};
    tbl[2] = '{1, 0, 1, 0, 1, 19, 400, 0, 0, 0, 1};
    tbl[3] = '{1, 0, 1, 0, 1, 20, 400, 0, 0, 0, 1};
    tbl[4] = '{1, 0, 1, 0, 1, 21, 400, 0, 0, 0, 1};
    tbl[5] = '{1, 1, 1, 0, 1, 21, 400, 0, 0, 0, 0};
    tbl[6] = '{1, 1, 0, 1, 1, 21, 400, 0, 0, 1, 0};
    tbl[7] = '{1, 1, 0, 0, 1, 20, 400, 0, 0, 1, 1};
    tbl[8] = '{0, 0, 1, 0, 1, 20, 400, 0, 0, 1, 1};
    tbl[9] = '{1, 0, 0, 0, 1, 20, 400, 0, 0, 1, 0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_x", int'(pos_x), INIT_X);
    chk("reset_y", int'(pos_y), INIT_Y);
    chk("reset_vel", int'(vel_y), 0);
    chk("reset_st", int'(mstate), 2);
    chk("reset_face", int'(facing), 0);
    chk("reset_walk", int'(walking), 0);
    rst_n = 1'b1;

    // Walking table.
    for (int i = 0; i < 10; i++) begin
      move_left = (tbl[i].l != 0); move_right = (tbl[i].r != 0);
      blk_left = (tbl[i].bl != 0); blk_down = (tbl[i].bd != 0);
      step(tbl[i].t != 0, "tbl");
      chk($sformatf("tbl%0d_x", i), int'(pos_x), tbl[i].ex);
      chk($sformatf("tbl%0d_y", i), int'(pos_y), tbl[i].ey);
      chk($sformatf("tbl%0d_vel", i), int'(vel_y), tbl[i].ev);
      chk($sformatf("tbl%0d_st", i), int'(mstate), tbl[i].es);
      chk($sformatf("tbl%0d_face", i), int'(facing), tbl[i].ef);
      chk($sformatf("tbl%0d_walk", i), int'(walking), tbl[i].ew);
    end
    keys(0, 0, 0); blk_left = 1'b0;

    // Full jump with button held to the apex, then fall and land.
    keys(0, 0, 1); blk(0, 1);
    step(1'b1, "launch");
    chk("launch_vel", int'(vel_y), 12);
    chk("launch_y", int'(pos_y), 388);
    chk("launch_st", int'(mstate), 1);
    blk(0, 0);
    for (int i = 0; i < 11; i++) step(1'b1, "rise");
    chk("apex_y", int'(pos_y), 322);
    chk("apex_vel", int'(vel_y), 1);
    step(1'b1, "apex");
    chk("apex_fall_st", int'(mstate), 2);
    keys(0, 0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, "fall");
    blk(0, 1);
    step(1'b1, "land");
    chk("land_st", int'(mstate), 0);
    chk("land_vel", int'(vel_y), 0);

    // Jump cut on release at vel 10.
    keys(0, 0, 1);
    step(1'b1, "cut_launch");
    blk(0, 0);
    step(1'b1, "cut_rise");
    step(1'b1, "cut_rise");
    chk("cut_pre_vel", int'(vel_y), 10);
    keys(0, 0, 0);
    step(1'b1, "cut");
    chk("cut_vel", int'(vel_y), 4);
    step(1'b1, "cut_next");
    chk("cut_next_vel", int'(vel_y), 3);
    for (int i = 0; i < 4; i++) step(1'b1, "cut_fall");
    blk(0, 1);
    step(1'b1, "cut_land");

    // Ceiling bump during RISE.
    keys(0, 0, 1);
    step(1'b1, "bump_launch");
    blk(1, 0);
    step(1'b1, "bump");
    chk("bump_vel", int'(vel_y), 0);
    chk("bump_st", int'(mstate), 2);
    blk(0, 0); keys(0, 0, 0);
    step(1'b1, "bump_fall");
    blk(0, 1);
    step(1'b1, "bump_land");

    // Coyote jump two ticks after leaving the ledge.
    keys(0, 0, 0); blk(0, 0);
    do_respawn(300, 100);
    blk(0, 1);
    step(1'b1, "co_land");
    blk(0, 0);
    step(1'b1, "co_drop");
    chk("co_drop_st", int'(mstate), 2);
    step(1'b1, "co_fall");
    keys(0, 0, 1);
    step(1'b1, "co_ok");
    chk("coyote_ok_vel", int'(vel_y), 12);
    chk("coyote_ok_st", int'(mstate), 1);
    keys(0, 0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, "co_rise");
    blk(0, 1);
    step(1'b1, "co_land2");
    // Late press: coyote window expired.
    blk(0, 0);
    for (int i = 0; i < 4; i++) step(1'b1, "co_late_fall");
    keys(0, 0, 1);
    step(1'b1, "co_late");
    chk("coyote_late_vel", int'(vel_y), -4);
    chk("coyote_late_st", int'(mstate), 2);
    keys(0, 0, 0);
    for (int i = 0; i < 10; i++) step(1'b1, "term");
    chk("terminal_vel", int'(vel_y), -14);
    step(1'b1, "term_hold");
    chk("terminal_hold_vel", int'(vel_y), -14);

    // Jump buffer: press two ticks before landing.
    do_respawn(300, 100);
    blk(0, 0); keys(0, 0, 1);
    step(1'b0, "buf_press");
    step(1'b1, "buf_fall");
    blk(0, 1);
    step(1'b1, "buf_land");
    chk("buf_land_st", int'(mstate), 0);
    step(1'b1, "buf_launch");
    chk("buf_launch_vel", int'(vel_y), 12);
    keys(0, 0, 0); blk(0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, "buf_rise");
    // Press four ticks before landing: buffer expires.
    do_respawn(300, 100);
    blk(0, 0); keys(0, 0, 1);
    step(1'b0, "buf2_press");
    for (int i = 0; i < 3; i++) step(1'b1, "buf2_fall");
    blk(0, 1);
    step(1'b1, "buf2_land");
    step(1'b1, "buf2_after");
    chk("buf_expired_st", int'(mstate), 0);
    chk("buf_expired_vel", int'(vel_y), 0);
    keys(0, 0, 0);

    // Horizontal clamps.
    do_respawn(0, 200);
    keys(1, 0, 0);
    step(1'b1, "x0");
    chk("x0_x", int'(pos_x), 0);
    chk("x0_face", int'(facing), 1);
    keys(0, 0, 0);
    do_respawn(X_MAX, 200);
    chk("respawn_keeps_face", int'(facing), 1);
    keys(0, 1, 0);
    step(1'b1, "xmax");
    chk("xmax_x", int'(pos_x), X_MAX);
    keys(0, 0, 0);

    // Bottom clamp forces GROUND.
    do_respawn(300, 470);
    blk(0, 0);
    for (int i = 0; i < 4; i++) step(1'b1, "ymax");
    chk("ymax_y", int'(pos_y), Y_MAX);
    chk("ymax_st", int'(mstate), 0);
    chk("ymax_vel", int'(vel_y), 0);

    // Asynchronous reset mid-jump.
    blk(0, 1); keys(0, 0, 1);
    step(1'b1, "rst_launch");
    blk(0, 0);
    step(1'b1, "rst_rise");
    step(1'b1, "rst_rise");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_x", int'(pos_x), INIT_X);
    chk("midrst_y", int'(pos_y), INIT_Y);
    chk("midrst_vel", int'(vel_y), 0);
    chk("midrst_st", int'(mstate), 2);
    keys(0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      move_left  = 1'($urandom_range(0, 1));
      move_right = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) jump_btn = ~jump_btn;
      blk_up    = ($urandom_range(0, 7) == 0);
      blk_down  = ($urandom_range(0, 2) == 0);
      blk_left  = ($urandom_range(0, 3) == 0);
      blk_right = ($urandom_range(0, 3) == 0);
      respawn   = ($urandom_range(0, 59) == 0);
      spawn_x   = 10'($urandom_range(0, X_MAX));
      spawn_y   = 9'($urandom_range(0, Y_MAX));
      step($urandom_range(0, 2) == 0, "rand");
      respawn = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
